// File: rtl/fetch_sequencer.sv
// fetch_sequencer: per-cycle control of the instruction fetch stage.
// Chooses whether the PC advances and from which source (PC+4, branch
// target, JR register), drives IF/ID and ID/EX write/flush, absorbs a
// fixed instruction-memory wait, stalls on load-use, stops on halt, and
// keeps saturating stall/redirect counters.
module fetch_sequencer #(
  parameter int IMEM_WAIT = 0,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             BranchTaken,
  input  logic             JumpReg,
  input  logic             LoadUse,
  input  logic             Halt,
  output logic             IMemReq,
  output logic             PCWrite,
  output logic [1:0]       PCSel,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  // The wait counter only ever needs to reach IMEM_WAIT.
  localparam int                WAIT_W   = (IMEM_WAIT > 0) ? $clog2(IMEM_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(IMEM_WAIT);

  localparam logic [1:0] SEL_PC4 = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_JR  = 2'b10;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_HALT
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              wait_pending;
  logic              stall_inc;
  logic              flush_inc;

  // The counter never exceeds WAIT_MAX, so inequality means "still waiting";
  // with IMEM_WAIT = 0 this is constantly false.
  assign wait_pending = (wait_cnt != WAIT_MAX);

  // Next-state, wait-counter and control-output decode of state plus hazards.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    wait_next  = wait_cnt;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    IMemReq    = 1'b0;
    PCWrite    = 1'b0;
    PCSel      = SEL_PC4;
    IFIDWrite  = 1'b0;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    Halted     = 1'b0;

    // While reset is held every control output stays at its idle value.
    if (Reset) begin
      unique case (state)
        S_BOOT: begin
          IFIDFlush  = 1'b1;
          IDEXFlush  = 1'b1;
          state_next = S_FETCH;
        end

        S_FETCH: begin
          IMemReq = 1'b1;
          if (BranchTaken) begin
            // Redirect to branch target; both younger stages are squashed.
            PCSel     = SEL_BR;
            PCWrite   = 1'b1;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
            wait_next = '0;
            flush_inc = 1'b1;
          end else if (JumpReg) begin
            // JR resolves in ID, so only IF/ID holds a wrong-path instruction.
            PCSel     = SEL_JR;
            PCWrite   = 1'b1;
            IFIDFlush = 1'b1;
            wait_next = '0;
            flush_inc = 1'b1;
          end else if (Halt) begin
            IFIDFlush  = 1'b1;
            state_next = S_HALT;
          end else if (LoadUse) begin
            // Hold IF and ID, bubble into EX; a pending memory wait keeps
            // counting so the two stalls overlap.
            IDEXFlush = 1'b1;
            stall_inc = 1'b1;
            if (wait_pending) begin
              wait_next = wait_cnt + 1'b1;
            end
          end else if (wait_pending) begin
            IFIDFlush = 1'b1;
            wait_next = wait_cnt + 1'b1;
            stall_inc = 1'b1;
          end else begin
            PCSel     = SEL_PC4;
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
            wait_next = '0;
          end
        end

        S_HALT: begin
          Halted = 1'b1;
        end

        default: begin
          state_next = S_BOOT;
        end
      endcase
    end
  end

  // State, wait counter and saturating performance counters.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_BOOT;
      wait_cnt   <= '0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state    <= state_next;
      wait_cnt <= wait_next;
      if (stall_inc && (StallCount != '1)) begin
        StallCount <= StallCount + 1'b1;
      end
      if (flush_inc && (FlushCount != '1)) begin
        FlushCount <= FlushCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: four instances with different memory waits and
// counter widths share the same stimulus, each checked against a
// cycle-level reference model of the fetch rules.
module tb_fetch_sequencer;

  logic Clk         = 1'b0;
  logic Reset       = 1'b0;
  logic BranchTaken = 1'b0;
  logic JumpReg     = 1'b0;
  logic LoadUse     = 1'b0;
  logic Halt        = 1'b0;

  typedef struct packed {
    logic        imem_req;
    logic        pc_write;
    logic [1:0]  pc_sel;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        halted;
    logic [15:0] stall;
    logic [15:0] flush;
  } obs_t;

  // Instance k: 0 -> wait 0, 1 -> wait 2, 2 -> wait 3, 3 -> wait 1 with 4-bit counters.
  function automatic int wait_of(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int cw_of(input int k);
    return (k == 3) ? 4 : 16;
  endfunction

  obs_t obs [4];

  for (genvar k = 0; k < 4; k++) begin : g_dut
    logic                imem_req, pc_write, ifid_write, ifid_flush, idex_flush, halted;
    logic [1:0]          pc_sel;
    logic [cw_of(k)-1:0] stall, flush;

    fetch_sequencer #(.IMEM_WAIT(wait_of(k)), .CNT_W(cw_of(k))) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .BranchTaken(BranchTaken),
      .JumpReg    (JumpReg),
      .LoadUse    (LoadUse),
      .Halt       (Halt),
      .IMemReq    (imem_req),
      .PCWrite    (pc_write),
      .PCSel      (pc_sel),
      .IFIDWrite  (ifid_write),
      .IFIDFlush  (ifid_flush),
      .IDEXFlush  (idex_flush),
      .Halted     (halted),
      .StallCount (stall),
      .FlushCount (flush)
    );

    assign obs[k] = {imem_req, pc_write, pc_sel, ifid_write, ifid_flush, idex_flush,
                     halted, 16'(stall), 16'(flush)};
  end

  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: phase of each sequencer, fetch wait progress, counters.
  localparam int P_BOOT  = 0;
  localparam int P_FETCH = 1;
  localparam int P_HALT  = 2;

  int phase   [4];
  int waited  [4];
  int stalls  [4];
  int flushes [4];

  function automatic obs_t model_out(input int k);
    obs_t e;
    e = '0;
    if (Reset !== 1'b1) return e;
    e.stall = 16'(stalls[k]);
    e.flush = 16'(flushes[k]);
    if (phase[k] == P_BOOT) begin
      e.ifid_flush = 1'b1;
      e.idex_flush = 1'b1;
    end else if (phase[k] == P_HALT) begin
      e.halted = 1'b1;
    end else begin
      e.imem_req = 1'b1;
      if (BranchTaken) begin
        e.pc_sel = 2'b01; e.pc_write = 1'b1; e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
      end else if (JumpReg) begin
        e.pc_sel = 2'b10; e.pc_write = 1'b1; e.ifid_flush = 1'b1;
      end else if (Halt) begin
        e.ifid_flush = 1'b1;
      end else if (LoadUse) begin
        e.idex_flush = 1'b1;
      end else if (waited[k] < wait_of(k)) begin
        e.ifid_flush = 1'b1;
      end else begin
        e.pc_write = 1'b1; e.ifid_write = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic int sat_inc(input int v, input int k);
    return (v < (1 << cw_of(k)) - 1) ? v + 1 : v;
  endfunction

  task automatic model_tick();
    for (int k = 0; k < 4; k++) begin
      if (Reset !== 1'b1) continue;
      if (phase[k] == P_BOOT) begin
        phase[k] = P_FETCH;
      end else if (phase[k] == P_FETCH) begin
        if (BranchTaken || JumpReg) begin
          waited[k]  = 0;
          flushes[k] = sat_inc(flushes[k], k);
        end else if (Halt) begin
          phase[k] = P_HALT;
        end else if (LoadUse) begin
          stalls[k] = sat_inc(stalls[k], k);
          if (waited[k] < wait_of(k)) waited[k]++;
        end else if (waited[k] < wait_of(k)) begin
          waited[k]++;
          stalls[k] = sat_inc(stalls[k], k);
        end else begin
          waited[k] = 0;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      phase[k] = P_BOOT; waited[k] = 0; stalls[k] = 0; flushes[k] = 0;
    end
  endtask

  task automatic drive(input logic b, input logic j, input logic h, input logic l);
    BranchTaken = b; JumpReg = j; Halt = h; LoadUse = l;
  endtask

  // Clock edge: advance the model with the inputs the DUT sampled, then
  // move the inputs away from the edge.
  task automatic tick();
    @(posedge Clk);
    model_tick();
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    Reset = 1'b0;
    model_reset();
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset = 1'b1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0);
    Reset = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge Clk);
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs[k] !== 40'h0) begin
          miscompares++;
          $display("FAIL reset_hold dut%0d: got %h want %h", k, obs[k], 40'h0);
        end
      end
      @(posedge Clk);
    end
    #1 Reset = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs[k] !== model_out(k)) begin
        miscompares++;
        $display("FAIL boot_cycle dut%0d: got %h want %h", k, obs[k], model_out(k));
      end
    end
    vectors++;
    if (obs[0].ifid_flush !== 1'b1 || obs[0].pc_write !== 1'b0) begin
      miscompares++;
      $display("FAIL boot_flush: got flush=%b pcw=%b want flush=1 pcw=0",
               obs[0].ifid_flush, obs[0].pc_write);
    end
    tick();
  endtask

  // Nine hazard-free fetch cycles straight after BOOT.
  task automatic test_stream();
    int pulses0, pulses2;
    pulses0 = 0; pulses2 = 0;
    drive(0, 0, 0, 0);
    repeat (9) begin
      @(negedge Clk);
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs[k] !== model_out(k)) begin
          miscompares++;
          $display("FAIL stream dut%0d: got %h want %h", k, obs[k], model_out(k));
        end
      end
      if (obs[0].pc_write === 1'b1) pulses0++;
      if (obs[1].pc_write === 1'b1) pulses2++;
      tick();
    end
    @(negedge Clk);
    vectors++;
    if (pulses0 !== 9 || pulses2 !== 3) begin
      miscompares++;
      $display("FAIL stream_pulses: got %0d/%0d want 9/3", pulses0, pulses2);
    end
    vectors++;
    if (obs[1].stall !== 16'd6 || obs[0].stall !== 16'd0 || obs[0].flush !== 16'd0) begin
      miscompares++;
      $display("FAIL stream_counts: got w2stall=%0d w0stall=%0d w0flush=%0d want 6 0 0",
               obs[1].stall, obs[0].stall, obs[0].flush);
    end
  endtask

  // Branch, JR and load-use together: branch must win alone.
  task automatic test_priority();
    do_reset();
    tick();
    drive(1, 1, 0, 1);
    @(negedge Clk);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs[k] !== model_out(k)) begin
        miscompares++;
        $display("FAIL priority dut%0d: got %h want %h", k, obs[k], model_out(k));
      end
    end
    tick();
    drive(0, 0, 0, 0);
    @(negedge Clk);
    vectors++;
    if (obs[0].flush !== 16'd1 || obs[0].stall !== 16'd0) begin
      miscompares++;
      $display("FAIL priority_counts: got flush=%0d stall=%0d want 1 0",
               obs[0].flush, obs[0].stall);
    end
  endtask

  // Two load-use cycles then a clean cycle on the single-cycle memory.
  task automatic test_load_use();
    do_reset();
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, (c < 2));
      @(negedge Clk);
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs[k] !== model_out(k)) begin
          miscompares++;
          $display("FAIL load_use c%0d dut%0d: got %h want %h", c, k, obs[k], model_out(k));
        end
      end
      vectors++;
      if (obs[0].pc_write !== (c == 2) || obs[0].idex_flush !== (c < 2)) begin
        miscompares++;
        $display("FAIL load_use_w0 c%0d: got pcw=%b idex=%b want %b %b",
                 c, obs[0].pc_write, obs[0].idex_flush, (c == 2), (c < 2));
      end
      tick();
    end
    @(negedge Clk);
    vectors++;
    if (obs[0].stall !== 16'd2) begin
      miscompares++;
      $display("FAIL load_use_count: got %0d want 2", obs[0].stall);
    end
  endtask

  // Branch after one wait cycle on the 3-wait memory aborts the fetch.
  task automatic test_branch_abort();
    int first;
    first = 0;
    do_reset();
    tick();
    drive(0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0);
    @(negedge Clk);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs[k] !== model_out(k)) begin
        miscompares++;
        $display("FAIL abort_redirect dut%0d: got %h want %h", k, obs[k], model_out(k));
      end
    end
    tick();
    drive(0, 0, 0, 0);
    for (int n = 1; n <= 8; n++) begin
      @(negedge Clk);
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs[k] !== model_out(k)) begin
          miscompares++;
          $display("FAIL abort_refetch n%0d dut%0d: got %h want %h", n, k, obs[k], model_out(k));
        end
      end
      if (first == 0 && obs[2].pc_write === 1'b1) first = n;
      tick();
    end
    vectors++;
    if (first !== 4) begin
      miscompares++;
      $display("FAIL abort_latency: got %0d want 4", first);
    end
  endtask

  // Halt freezes everything; an asynchronous reset pulse restarts from BOOT.
  task automatic test_halt();
    do_reset();
    tick();
    drive(0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0);
    tick();
    for (int c = 0; c < 6; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      @(negedge Clk);
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs[k] !== model_out(k)) begin
          miscompares++;
          $display("FAIL halted c%0d dut%0d: got %h want %h", c, k, obs[k], model_out(k));
        end
      end
      vectors++;
      if (obs[0].halted !== 1'b1 || obs[0].pc_write !== 1'b0 || obs[0].imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL halted_w0 c%0d: got halted=%b pcw=%b req=%b want 1 0 0",
                 c, obs[0].halted, obs[0].pc_write, obs[0].imem_req);
      end
      if (c < 5) tick();
    end
    #2 Reset = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs[k] !== 40'h0) begin
        miscompares++;
        $display("FAIL halt_reset dut%0d: got %h want %h", k, obs[k], 40'h0);
      end
    end
    drive(0, 0, 0, 0);
    tick();
    Reset = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs[k] !== model_out(k)) begin
        miscompares++;
        $display("FAIL halt_reboot dut%0d: got %h want %h", k, obs[k], model_out(k));
      end
    end
    tick();
  endtask

  // Long stall and redirect runs saturate the 4-bit counters.
  task automatic test_saturation();
    do_reset();
    tick();
    for (int c = 0; c < 40; c++) begin
      drive((c >= 20), 0, 0, (c < 20));
      @(negedge Clk);
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs[k] !== model_out(k)) begin
          miscompares++;
          $display("FAIL saturation c%0d dut%0d: got %h want %h", c, k, obs[k], model_out(k));
        end
      end
      tick();
    end
    @(negedge Clk);
    vectors++;
    if (obs[3].stall !== 16'd15 || obs[3].flush !== 16'd15) begin
      miscompares++;
      $display("FAIL saturation_cnt4: got stall=%0d flush=%0d want 15 15",
               obs[3].stall, obs[3].flush);
    end
    vectors++;
    if (obs[0].stall !== 16'd20 || obs[0].flush !== 16'd20) begin
      miscompares++;
      $display("FAIL saturation_cnt16: got stall=%0d flush=%0d want 20 20",
               obs[0].stall, obs[0].flush);
    end
  endtask

  // Randomized hazard mix, re-reset a few cycles after each halt.
  task automatic test_random();
    int halt_cycles;
    halt_cycles = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (phase[0] == P_HALT) halt_cycles++;
      if (halt_cycles > 3) begin
        halt_cycles = 0;
        do_reset();
      end
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0));
      @(negedge Clk);
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs[k] !== model_out(k)) begin
          miscompares++;
          $display("FAIL random c%0d dut%0d: got %h want %h", c, k, obs[k], model_out(k));
        end
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_priority();
    test_load_use();
    test_branch_abort();
    test_halt();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
